// File: rtl/uart_tx_engine_pkg.sv
// Shared UART transmit definitions: FIFO sizing, line-control bit positions,
// serialiser state codes and the small helpers used when a character is popped.
package uart_tx_engine_pkg;

    localparam int UART_FIFO_DEPTH     = 16;
    localparam int UART_FIFO_PTR_W     = 4;
    localparam int UART_FIFO_COUNTER_W = 5;

    // lcr field positions; the word-length field occupies [UART_LC_BITS +: 2]
    localparam int UART_LC_BITS = 0;
    localparam int UART_LC_SB   = 2;
    localparam int UART_LC_PE   = 3;
    localparam int UART_LC_EP   = 4;
    localparam int UART_LC_SP   = 5;
    localparam int UART_LC_BC   = 6;

    localparam logic [4:0] UART_TICK_LAST = 5'd15;

    typedef enum logic [2:0] {
        UART_TS_IDLE   = 3'd0,
        UART_TS_START  = 3'd1,
        UART_TS_DATA   = 3'd2,
        UART_TS_PARITY = 3'd3,
        UART_TS_STOP   = 3'd4
    } tx_state_e;

    // Stop length minus one, in 16x ticks: 1, 1.5 (5-bit words) or 2 bits
    function automatic logic [4:0] stop_ticks_m1(input logic sb, input logic [1:0] wlen);
        if (!sb)
            return 5'd15;
        else if (wlen == 2'd0)
            return 5'd23;
        else
            return 5'd31;
    endfunction

    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] wlen,
                                        input logic ep, input logic sp);
        logic [7:0] mask;
        logic       x;
        case (wlen)
            2'd0:    mask = 8'h1F;
            2'd1:    mask = 8'h3F;
            2'd2:    mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        x = ^(data & mask);
        if (sp)
            return ~ep;
        else
            return ep ? x : ~x;
    endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Register-file side of the transmit engine: line control, push path,
// baud tick and the status/line signals returned to the register file.
interface uart_tx_engine_if
    import uart_tx_engine_pkg::*;
#(
    parameter int COUNTER_W = UART_FIFO_COUNTER_W
);
    logic [7:0]           lcr;
    logic                 tf_push;
    logic [7:0]           wb_dat_i;
    logic                 enable;
    logic                 tx_reset;
    logic                 stx_pad_o;
    logic [2:0]           tstate;
    logic [COUNTER_W-1:0] tf_count;

    modport master (
        output lcr, tf_push, wb_dat_i, enable, tx_reset,
        input  stx_pad_o, tstate, tf_count
    );

    modport slave (
        input  lcr, tf_push, wb_dat_i, enable, tx_reset,
        output stx_pad_o, tstate, tf_count
    );
endinterface

// File: rtl/uart_tx_engine_fifo.sv
// Transmit FIFO: circular byte store with a combinational head read,
// synchronous clear that wins over a same-cycle push, and an occupancy count.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [7:0]       i_data,
    input  logic             i_pop,
    output logic [7:0]       o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);
    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rptr];
    assign o_count   = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok)
                r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop_ok)
                r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define which entries are valid
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_clear)
            r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: FIFO plus a 16x-tick serialiser producing start,
// 5..8 data bits, optional parity and 1/1.5/2 stop bits on stx_pad_o.
module uart_tx_engine
    import uart_tx_engine_pkg::*;
#(
    parameter int FIFO_DEPTH = UART_FIFO_DEPTH,
    parameter int FIFO_PTR_W = UART_FIFO_PTR_W,
    parameter int COUNTER_W  = UART_FIFO_COUNTER_W
) (
    input  logic            clk,
    input  logic            wb_rst_n,
    uart_tx_engine_if.slave bus
);
    tx_state_e      r_state;
    logic [4:0]     r_tick;
    logic [2:0]     r_bit_idx;
    logic           r_tx;
    logic [1:0]     r_wlen;
    logic           r_stop2;
    logic           r_par_en;
    logic [7:0]     r_shift;
    logic           r_parity;

    logic [7:0]           w_head;
    logic [COUNTER_W-1:0] w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_tick_end;
    logic                 w_pop;
    logic                 w_shift;

    assign w_push     = bus.tf_push && !w_full;
    assign w_tick_end = (r_tick == '0);
    // A new character starts from IDLE or straight out of the last stop tick
    assign w_pop      = bus.enable && !w_empty &&
                        ((r_state == UART_TS_IDLE) || ((r_state == UART_TS_STOP) && w_tick_end));
    assign w_shift    = bus.enable && (r_state == UART_TS_DATA) && w_tick_end;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .PTR_W (FIFO_PTR_W),
        .CNT_W (COUNTER_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (wb_rst_n),
        .i_clear (bus.tx_reset),
        .i_push  (w_push),
        .i_data  (bus.wb_dat_i),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state   <= UART_TS_IDLE;
            r_tick    <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_wlen    <= '0;
            r_stop2   <= 1'b0;
            r_par_en  <= 1'b0;
        end else if (bus.enable) begin
            if (w_pop) begin
                r_state  <= UART_TS_START;
                r_tick   <= UART_TICK_LAST;
                r_tx     <= 1'b0;
                r_wlen   <= bus.lcr[UART_LC_BITS +: 2];
                r_stop2  <= bus.lcr[UART_LC_SB];
                r_par_en <= bus.lcr[UART_LC_PE];
            end else if (r_state != UART_TS_IDLE) begin
                if (!w_tick_end) begin
                    r_tick <= r_tick - 5'd1;
                end else begin
                    r_tick <= UART_TICK_LAST;
                    case (r_state)
                        UART_TS_START: begin
                            r_state   <= UART_TS_DATA;
                            r_bit_idx <= '0;
                            r_tx      <= r_shift[0];
                        end
                        UART_TS_DATA: begin
                            // Last data bit index is 4 + word-length code
                            if (r_bit_idx == {1'b1, r_wlen}) begin
                                if (r_par_en) begin
                                    r_state <= UART_TS_PARITY;
                                    r_tx    <= r_parity;
                                end else begin
                                    r_state <= UART_TS_STOP;
                                    r_tx    <= 1'b1;
                                    r_tick  <= stop_ticks_m1(r_stop2, r_wlen);
                                end
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                                r_tx      <= r_shift[1];
                            end
                        end
                        UART_TS_PARITY: begin
                            r_state <= UART_TS_STOP;
                            r_tx    <= 1'b1;
                            r_tick  <= stop_ticks_m1(r_stop2, r_wlen);
                        end
                        default: begin
                            r_state <= UART_TS_IDLE;
                            r_tx    <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    // Shifter and parity are captured together with the character's lcr
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_shift  <= w_head;
            r_parity <= parity_bit(w_head, bus.lcr[UART_LC_BITS +: 2],
                                   bus.lcr[UART_LC_EP], bus.lcr[UART_LC_SP]);
        end else if (w_shift) begin
            r_shift <= r_shift >> 1;
        end
    end

    assign bus.stx_pad_o = r_tx & ~bus.lcr[UART_LC_BC];
    assign bus.tstate    = r_state;
    assign bus.tf_count  = w_count;

endmodule
